// File: rtl/list_op_master.sv
// list_op_master: host-side initiator for the list-operation interface.
//
// A host command is accepted on a valid/ready channel and turned into one
// list operation. The operation is a single-cycle list_op_en strobe with
// operands that stay stable. The block waits for list_op_done, then returns
// the list result on a valid/ready response channel. Only one operation is
// outstanding at a time.
//
// Reads and writes with an out-of-range index, and the reserved opcode, are
// rejected locally. These never reach the list.
//
// Build option: define LIST_OP_MASTER_TIMEOUT_EN to add a watchdog on the
// WAIT state. After TIMEOUT_CYCLES cycles with no list_op_done, the block
// aborts the operation. The response then carries rsp_error=1 and an
// all-ones rsp_data marker.

module list_op_master #(
    parameter int  DATA_WIDTH     = 32,
    parameter int  LENGTH         = 8,
    parameter int  TIMEOUT_CYCLES = 1024,
    localparam int LENGTH_WIDTH   = $clog2(LENGTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    // host command channel
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [2:0]                       cmd_op,
    input  logic [DATA_WIDTH-1:0]            cmd_data,
    input  logic [LENGTH_WIDTH-1:0]          cmd_index,
    // host response channel
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [LENGTH_WIDTH+DATA_WIDTH-1:0] rsp_data,
    output logic                             rsp_error,
    output logic [2:0]                       rsp_op,
    // list side
    output logic [2:0]                       list_op_sel,
    output logic                             list_op_en,
    output logic [DATA_WIDTH-1:0]            list_data,
    output logic [LENGTH_WIDTH-1:0]          list_index,
    input  logic [LENGTH_WIDTH+DATA_WIDTH-1:0] list_result,
    input  logic                             list_op_done,
    input  logic                             list_op_error,
    // status
    output logic                             busy
);

    localparam int RSP_WIDTH = LENGTH_WIDTH + DATA_WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [2:0] OP_READ  = 3'b000;
    localparam logic [2:0] OP_WRITE = 3'b001;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    localparam logic [LENGTH_WIDTH-1:0] LENGTH_IDX = LENGTH_WIDTH'(LENGTH);

    logic [1:0]              state_q,     state_d;
    logic [2:0]              op_q,        op_d;
    logic [DATA_WIDTH-1:0]   data_q,      data_d;
    logic [LENGTH_WIDTH-1:0] index_q,     index_d;
    logic [RSP_WIDTH-1:0]    rsp_data_q,  rsp_data_d;
    logic                    rsp_error_q, rsp_error_d;
    logic                    cmd_reject;

`ifdef LIST_OP_MASTER_TIMEOUT_EN
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
`else
    // TIMEOUT_CYCLES only sizes the watchdog, which this build omits.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    // Reject commands that the list must never see: the reserved opcode, or
    // a read/write whose index is outside the list.
    assign cmd_reject = (cmd_op == OP_RSVD) ||
                        (((cmd_op == OP_READ) || (cmd_op == OP_WRITE)) &&
                         (cmd_index >= LENGTH_IDX));

    // Next-state and datapath decisions for the IDLE/ISSUE/WAIT/RESP sequence.
    always_comb begin
        // NOTE: every variable gets its hold value first, so branches that do
        // not assign it cannot infer a latch.
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        index_d     = index_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
`ifdef LIST_OP_MASTER_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d        = cmd_op;
                    data_d      = cmd_data;
                    index_d     = cmd_index;
                    rsp_data_d  = '0;
                    rsp_error_d = cmd_reject;
                    state_d     = cmd_reject ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef LIST_OP_MASTER_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                // If list_op_done and watchdog expiry land in the same
                // cycle, the completion wins.
                if (list_op_done) begin
                    rsp_data_d  = list_result;
                    rsp_error_d = list_op_error;
                    state_d     = S_RESP;
                end
`ifdef LIST_OP_MASTER_TIMEOUT_EN
                else if (wait_cnt_q == CNT_LAST) begin
                    rsp_data_d  = '1;
                    rsp_error_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and operand/result registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            data_q      <= '0;
            index_q     <= '0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register update from
            // the same pre-edge values, whatever order the statements are in.
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            index_q     <= index_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
        end
    end

`ifdef LIST_OP_MASTER_TIMEOUT_EN
    // WAIT-state watchdog counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign list_op_en  = (state_q == S_ISSUE);
    assign rsp_valid   = (state_q == S_RESP);
    assign list_op_sel = op_q;
    assign rsp_op      = op_q;
    assign list_data   = data_q;
    assign list_index  = index_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_error   = rsp_error_q;

endmodule

// File: tb/tb_list_op_master.sv
// Directed testbench for list_op_master. The bench acts as both the host and
// the list responder. Outputs are sampled 1 time unit after the rising edge.
module tb_list_op_master;

    localparam int DW = 32;
    localparam int LW = 4;
    localparam int RW = LW + DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [DW-1:0] cmd_data = '0;
    logic [LW-1:0] cmd_index = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [RW-1:0] rsp_data;
    logic          rsp_error;
    logic [2:0]    rsp_op;
    logic [2:0]    list_op_sel;
    logic          list_op_en;
    logic [DW-1:0] list_data;
    logic [LW-1:0] list_index;
    logic [RW-1:0] list_result = '0;
    logic          list_op_done = 1'b0;
    logic          list_op_error = 1'b0;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;

    // responder-side storage for the write/read scenario
    logic [DW-1:0] mem [8];

    list_op_master #(.DATA_WIDTH(DW), .LENGTH(8), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_index(cmd_index),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_error(rsp_error), .rsp_op(rsp_op),
        .list_op_sel(list_op_sel), .list_op_en(list_op_en), .list_data(list_data),
        .list_index(list_index), .list_result(list_result),
        .list_op_done(list_op_done), .list_op_error(list_op_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "bench watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one cycle; it is accepted on the edge.
    task automatic send_cmd(input logic [2:0] op, input logic [DW-1:0] data, input logic [LW-1:0] idx);
        cmd_op = op; cmd_data = data; cmd_index = idx; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Single-cycle list completion pulse.
    task automatic pulse_done(input logic [RW-1:0] result, input logic err);
        list_result = result; list_op_error = err; list_op_done = 1'b1;
        tick();
        list_op_done = 1'b0; list_op_error = 1'b0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        vectors++;
        if ({cmd_ready, rsp_valid, rsp_error, list_op_en, busy} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_flags: got {rdy,vld,err,en,busy}=%b want 10000",
                     {cmd_ready, rsp_valid, rsp_error, list_op_en, busy});
        end
        vectors++;
        if ({rsp_data, rsp_op, list_op_sel, list_data, list_index} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got rsp_data=%h rsp_op=%b sel=%b data=%h idx=%h want all 0",
                     rsp_data, rsp_op, list_op_sel, list_data, list_index);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        mem[3] = 32'hDEADBEEF;
        vectors++;
        if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL wr_cmd_ready: got %b want 1", cmd_ready); end
        send_cmd(3'b001, 32'hDEADBEEF, 4'd3);
        vectors++;
        if ({list_op_en, list_op_sel, list_index, list_data} !== {1'b1, 3'b001, 4'd3, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL wr_issue: got en=%b sel=%b idx=%0d data=%h want en=1 sel=001 idx=3 data=deadbeef",
                     list_op_en, list_op_sel, list_index, list_data);
        end
        vectors++;
        if ({cmd_ready, busy} !== 2'b01) begin miscompares++; $display("FAIL wr_busy: got rdy,busy=%b want 01", {cmd_ready, busy}); end
        tick();
        vectors++;
        if (list_op_en !== 1'b0) begin miscompares++; $display("FAIL wr_en_one_cycle: got %b want 0", list_op_en); end
        pulse_done({4'h0, 32'hDEADBEEF}, 1'b0);
        vectors++;
        if ({rsp_valid, rsp_error, rsp_op, rsp_data} !== {1'b1, 1'b0, 3'b001, 36'h0DEADBEEF}) begin
            miscompares++;
            $display("FAIL wr_rsp: got vld=%b err=%b op=%b data=%h want 1 0 001 0deadbeef",
                     rsp_valid, rsp_error, rsp_op, rsp_data);
        end
        handshake();
        vectors++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin miscompares++; $display("FAIL wr_release: got vld,rdy=%b want 01", {rsp_valid, cmd_ready}); end

        send_cmd(3'b000, 32'h0, 4'd3);
        vectors++;
        if ({list_op_en, list_op_sel, list_index} !== {1'b1, 3'b000, 4'd3}) begin
            miscompares++;
            $display("FAIL rd_issue: got en=%b sel=%b idx=%0d want 1 000 3", list_op_en, list_op_sel, list_index);
        end
        tick();
        pulse_done({4'h0, mem[3]}, 1'b0);
        vectors++;
        if ({rsp_valid, rsp_error, rsp_op, rsp_data} !== {1'b1, 1'b0, 3'b000, 36'h0DEADBEEF}) begin
            miscompares++;
            $display("FAIL rd_rsp: got vld=%b err=%b op=%b data=%h want 1 0 000 0deadbeef",
                     rsp_valid, rsp_error, rsp_op, rsp_data);
        end
        handshake();
    endtask

    task automatic test_local_reject();
        logic [2:0] ops [4];
        logic [3:0] idxs [4];
        logic       rej [4];
        ops[0] = 3'b000; idxs[0] = 4'd8; rej[0] = 1'b1;  // read past end
        ops[1] = 3'b111; idxs[1] = 4'd0; rej[1] = 1'b1;  // reserved opcode
        ops[2] = 3'b001; idxs[2] = 4'd7; rej[2] = 1'b0;  // last valid index
        ops[3] = 3'b010; idxs[3] = 4'd8; rej[3] = 1'b0;  // index ignored for find-all
        for (int i = 0; i < 4; i++) begin
            send_cmd(ops[i], 32'h0000_00A5, idxs[i]);
            if (rej[i]) begin
                vectors++;
                if ({rsp_valid, rsp_error, list_op_en, rsp_op, rsp_data} !== {1'b1, 1'b1, 1'b0, ops[i], 36'h0}) begin
                    miscompares++;
                    $display("FAIL reject_%0d: got vld=%b err=%b en=%b op=%b data=%h want 1 1 0 %b 0",
                             i, rsp_valid, rsp_error, list_op_en, rsp_op, rsp_data, ops[i]);
                end
            end else begin
                vectors++;
                if ({list_op_en, rsp_valid} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL noreject_%0d: got en,vld=%b want 10", i, {list_op_en, rsp_valid});
                end
                tick();
                pulse_done('0, 1'b0);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        send_cmd(3'b100, 32'h0, 4'd0);
        vectors++;
        if (list_op_en !== 1'b1) begin miscompares++; $display("FAIL bp_issue: got en=%b want 1", list_op_en); end
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if ({busy, rsp_valid} !== 2'b10) begin miscompares++; $display("FAIL bp_wait: got busy,vld=%b want 10", {busy, rsp_valid}); end
        pulse_done(36'h55, 1'b0);
        // next command waits while the response is held off
        cmd_op = 3'b000; cmd_index = 4'd1; cmd_data = '0; cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if ({rsp_valid, cmd_ready, rsp_op, rsp_data} !== {1'b1, 1'b0, 3'b100, 36'h55}) begin
                miscompares++;
                $display("FAIL bp_hold_%0d: got vld=%b rdy=%b op=%b data=%h want 1 0 100 55",
                         i, rsp_valid, cmd_ready, rsp_op, rsp_data);
            end
            tick();
        end
        handshake();
        vectors++;
        if ({rsp_valid, cmd_ready, list_op_en} !== 3'b010) begin
            miscompares++;
            $display("FAIL bp_after_hs: got vld,rdy,en=%b want 010", {rsp_valid, cmd_ready, list_op_en});
        end
        tick();
        cmd_valid = 1'b0;
        vectors++;
        if ({list_op_en, list_op_sel, list_index} !== {1'b1, 3'b000, 4'd1}) begin
            miscompares++;
            $display("FAIL bp_next_cmd: got en=%b sel=%b idx=%0d want 1 000 1", list_op_en, list_op_sel, list_index);
        end
        tick();
        pulse_done(36'h11, 1'b0);
        vectors++;
        if ({rsp_valid, rsp_data} !== {1'b1, 36'h11}) begin
            miscompares++;
            $display("FAIL bp_next_rsp: got vld=%b data=%h want 1 11", rsp_valid, rsp_data);
        end
        handshake();
    endtask

    task automatic test_error_and_stray();
        send_cmd(3'b110, 32'h0, 4'd0);
        rsp_ready = 1'b1;  // early ready must not release anything
        tick();
        vectors++;
        if ({busy, rsp_valid} !== 2'b10) begin miscompares++; $display("FAIL early_ready: got busy,vld=%b want 10", {busy, rsp_valid}); end
        rsp_ready = 1'b0;
        pulse_done(36'h123, 1'b1);
        vectors++;
        if ({rsp_valid, rsp_error, rsp_op, rsp_data} !== {1'b1, 1'b1, 3'b110, 36'h123}) begin
            miscompares++;
            $display("FAIL err_pass: got vld=%b err=%b op=%b data=%h want 1 1 110 123",
                     rsp_valid, rsp_error, rsp_op, rsp_data);
        end
        handshake();
        pulse_done(36'h999, 1'b1);  // stray done in IDLE
        vectors++;
        if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL stray_done: got vld,busy,rdy=%b want 001", {rsp_valid, busy, cmd_ready});
        end
        tick();
        vectors++;
        if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL stray_done_late: got vld=%b want 0", rsp_valid); end
    endtask

    task automatic test_reset_mid_wait();
        send_cmd(3'b001, 32'hCAFE_F00D, 4'd2);
        tick(); tick();
        rst = 1'b1;
        #1;
        vectors++;
        if ({cmd_ready, rsp_valid, rsp_error, list_op_en, busy} !== 5'b10000) begin
            miscompares++;
            $display("FAIL rst_mid_flags: got {rdy,vld,err,en,busy}=%b want 10000",
                     {cmd_ready, rsp_valid, rsp_error, list_op_en, busy});
        end
        vectors++;
        if ({rsp_data, rsp_op, list_op_sel, list_data, list_index} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_data: got sel=%b data=%h idx=%h want all 0", list_op_sel, list_data, list_index);
        end
        tick();
        rst = 1'b0;
        tick();
        send_cmd(3'b000, 32'h0, 4'd5);
        vectors++;
        if ({list_op_en, list_index} !== {1'b1, 4'd5}) begin
            miscompares++;
            $display("FAIL rst_mid_read_issue: got en=%b idx=%0d want 1 5", list_op_en, list_index);
        end
        tick();
        pulse_done(36'h77, 1'b0);
        vectors++;
        if ({rsp_valid, rsp_error, rsp_data} !== {1'b1, 1'b0, 36'h77}) begin
            miscompares++;
            $display("FAIL rst_mid_read_rsp: got vld=%b err=%b data=%h want 1 0 77", rsp_valid, rsp_error, rsp_data);
        end
        handshake();
    endtask

    task automatic test_timeout();
        int ticks_to_rsp;
        send_cmd(3'b011, 32'h42, 4'd0);
        vectors++;
        if (list_op_en !== 1'b1) begin miscompares++; $display("FAIL to_issue: got en=%b want 1", list_op_en); end
`ifdef LIST_OP_MASTER_TIMEOUT_EN
        // one tick into WAIT, sixteen WAIT cycles, then RESP
        ticks_to_rsp = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (rsp_valid === 1'b1) begin ticks_to_rsp = i; break; end
        end
        vectors++;
        if (ticks_to_rsp != 17) begin miscompares++; $display("FAIL to_latency: got %0d ticks want 17", ticks_to_rsp); end
        vectors++;
        if ({rsp_error, rsp_data} !== {1'b1, 36'hF_FFFF_FFFF}) begin
            miscompares++;
            $display("FAIL to_abort: got err=%b data=%h want 1 fffffffff", rsp_error, rsp_data);
        end
        pulse_done(36'h99, 1'b0);  // late done after abort
        vectors++;
        if ({rsp_valid, rsp_error, rsp_data} !== {1'b1, 1'b1, 36'hF_FFFF_FFFF}) begin
            miscompares++;
            $display("FAIL to_late_done: got vld=%b err=%b data=%h want 1 1 fffffffff", rsp_valid, rsp_error, rsp_data);
        end
        handshake();
        vectors++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin miscompares++; $display("FAIL to_release: got vld,rdy=%b want 01", {rsp_valid, cmd_ready}); end
`else
        ticks_to_rsp = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (rsp_valid === 1'b1 && ticks_to_rsp == 0) ticks_to_rsp = i;
        end
        vectors++;
        if ({busy, cmd_ready, ticks_to_rsp != 0} !== 3'b100) begin
            miscompares++;
            $display("FAIL to_hang: got busy=%b rdy=%b rsp_tick=%0d want busy=1 rdy=0 no rsp", busy, cmd_ready, ticks_to_rsp);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_local_reject();
        test_backpressure();
        test_error_and_stray();
        test_reset_mid_wait();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
